mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single setup/access style
//   memory port. A granted transfer walks IDLE -> SETUP -> ACCESS -> DONE. A
//   read returns one full line and a write carries one word. A transfer that
//   stays in ACCESS for TIMEOUT cycles without p_ready is completed with err
//   set and an all-zero line.
//
// Ports
//   clk, reset              clock (rising edge), async active-low reset
//   mN_req/rw/addr/size/wdata   requester N transfer request (N = 0, 1)
//   mN_done                 one-cycle completion pulse to the granted requester
//   rdata, err              result line and timeout flag, valid with mN_done
//   busy                    high while a transfer is in flight (SETUP..DONE)
//   psel, penable           memory select / enable
//   p_rw, p_addr, p_dsize, p_wdata   latched transfer attributes
//   p_rdata, p_ready        memory read line and completion
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int LINE_WIDTH = 512,
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 63
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_rw,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [1:0]            m0_size,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic                  m0_done,

    input  logic                  m1_req,
    input  logic                  m1_rw,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [1:0]            m1_size,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic                  m1_done,

    output logic [LINE_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy,

    output logic                  psel,
    output logic                  penable,
    output logic                  p_rw,
    output logic [ADDR_WIDTH-1:0] p_addr,
    output logic [1:0]            p_dsize,
    output logic [WORD_WIDTH-1:0] p_wdata,
    input  logic [LINE_WIDTH-1:0] p_rdata,
    input  logic                  p_ready
);

    // Counter value on the last ACCESS cycle that may still wait for p_ready.
    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    // Transfer attributes as they are latched at grant time.
    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            size;
        logic [WORD_WIDTH-1:0] wdata;
    } xfer_t;

    state_t                state_q,   state_d;
    xfer_t                 xfer_q,    xfer_d;
    logic [6:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  last_gnt_q, last_gnt_d;  // requester granted most recently
    logic                  owner_q,   owner_d;      // requester owning the current transfer
    logic                  psel_d, penable_d, busy_d, err_d;
    logic                  m0_done_d, m1_done_d;
    logic [LINE_WIDTH-1:0] rdata_d;

    xfer_t                 m0_x, m1_x;
    logic                  gnt_sel;

    assign m0_x = {m0_rw, m0_addr, m0_size, m0_wdata};
    assign m1_x = {m1_rw, m1_addr, m1_size, m1_wdata};

    assign p_rw    = xfer_q.rw;
    assign p_addr  = xfer_q.addr;
    assign p_dsize = xfer_q.size;
    assign p_wdata = xfer_q.wdata;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        xfer_d     = xfer_q;
        tmo_cnt_d  = tmo_cnt_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        psel_d     = psel;
        penable_d  = penable;
        busy_d     = busy;
        err_d      = err;
        rdata_d    = rdata;
        m0_done_d  = 1'b0;
        m1_done_d  = 1'b0;

        // On a tie the requester not served last wins; a lone requester wins
        // outright and the pointer is left alone until the grant happens.
        gnt_sel = (m0_req && m1_req) ? ~last_gnt_q : m1_req;

        unique case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d    = gnt_sel;
                    last_gnt_d = gnt_sel;
                    xfer_d     = gnt_sel ? m1_x : m0_x;
                    psel_d     = 1'b1;
                    penable_d  = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                tmo_cnt_d = '0;
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                // p_ready wins over an expiring timeout in the same cycle.
                if (p_ready) begin
                    if (!xfer_q.rw) begin
                        rdata_d = p_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 7'd1;
                    if (tmo_cnt_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_DONE;
                    end
                end

                if (state_d == S_DONE) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    m0_done_d = ~owner_q;
                    m1_done_d =  owner_q;
                end
            end

            S_DONE: begin
                // No grant here: a waiting request is picked up from IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            xfer_q     <= '0;
            tmo_cnt_q  <= '0;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            xfer_q     <= xfer_d;
            tmo_cnt_q  <= tmo_cnt_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            psel       <= psel_d;
            penable    <= penable_d;
            busy       <= busy_d;
            err        <= err_d;
            rdata      <= rdata_d;
            m0_done    <= m0_done_d;
            m1_done    <= m1_done_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A small memory model raises p_ready in
//   the mem_lat-th ACCESS cycle (never when mem_lat is 0) and returns a line
//   whose words encode the line address, so expected lines are computed
//   independently of the DUT. Inputs change and outputs are sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int LW = 512;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_rw, m1_req, m1_rw;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [1:0]    m0_size, m1_size;
    logic [WW-1:0] m0_wdata, m1_wdata;
    logic          m0_done, m1_done;
    logic [LW-1:0] rdata;
    logic          err, busy, psel, penable, p_rw;
    logic [AW-1:0] p_addr;
    logic [1:0]    p_dsize;
    logic [WW-1:0] p_wdata;
    logic [LW-1:0] p_rdata;
    logic          p_ready;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            mem_lat = 0;
    int            acc_cnt = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .WORD_WIDTH(WW), .TIMEOUT(63)) dut (
        .clk(clk), .reset(rst_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_size(m0_size),
        .m0_wdata(m0_wdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_size(m1_size),
        .m1_wdata(m1_wdata), .m1_done(m1_done),
        .rdata(rdata), .err(err), .busy(busy),
        .psel(psel), .penable(penable), .p_rw(p_rw), .p_addr(p_addr),
        .p_dsize(p_dsize), .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ready(p_ready)
    );

    always #5 clk = ~clk;

    // Line content: each word = BEEF, 0, line index, 00, word index.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) begin
            l[i*32 +: 32] = {16'hBEEF, 4'h0, a[11:6], 2'b00, 4'(i)};
        end
        return l;
    endfunction

    // Memory model.
    always @(negedge clk) begin
        p_ready = 1'b0;
        if (psel && penable) begin
            acc_cnt = acc_cnt + 1;
            if (mem_lat != 0 && acc_cnt == mem_lat) p_ready = 1'b1;
        end else begin
            acc_cnt = 0;
        end
        p_rdata = line_of(p_addr);
    end

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a done pulse; n is the number of falling edges taken.
    task automatic wait_done(input int limit, output int n, output logic d0, output logic d1);
        n  = 0;
        d0 = 1'b0;
        d1 = 1'b0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (m0_done || m1_done) begin
                d0 = m0_done;
                d1 = m1_done;
                return;
            end
        end
    endtask

    initial begin
        int            n;
        logic          d0, d1;
        logic [LW-1:0] exp_rdata;

        rst_n = 1'b0;
        m0_req = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_size = 2'b00; m0_wdata = '0;
        m1_req = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_size = 2'b00; m1_wdata = '0;
        p_ready = 1'b0; p_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_psel",    LW'(psel),    LW'(0));
        chk("rst_penable", LW'(penable), LW'(0));
        chk("rst_busy",    LW'(busy),    LW'(0));
        chk("rst_done",    LW'({m0_done, m1_done}), LW'(0));
        chk("rst_err",     LW'(err),     LW'(0));
        chk("rst_rdata",   rdata,        LW'(0));
        chk("rst_paddr",   LW'(p_addr),  LW'(0));
        rst_n = 1'b1;

        // Directed read, memory ready in the 50th ACCESS cycle
        mem_lat = 50; m0_rw = 1'b0; m0_addr = 12'h0C4; m0_size = 2'b00; m0_req = 1'b1;
        @(negedge clk);
        chk("rd_setup_psel",    LW'(psel),    LW'(1));
        chk("rd_setup_penable", LW'(penable), LW'(0));
        chk("rd_setup_busy",    LW'(busy),    LW'(1));
        chk("rd_setup_addr",    LW'(p_addr),  LW'(12'h0C4));
        chk("rd_setup_rw",      LW'(p_rw),    LW'(0));
        @(negedge clk);
        chk("rd_acc_psel",    LW'(psel),    LW'(1));
        chk("rd_acc_penable", LW'(penable), LW'(1));
        wait_done(100, n, d0, d1);
        chk("rd_latency", LW'(n),       LW'(50));
        chk("rd_m0_done", LW'(d0),      LW'(1));
        chk("rd_m1_done", LW'(d1),      LW'(0));
        chk("rd_rdata",   rdata,        line_of(12'h0C0));
        chk("rd_err",     LW'(err),     LW'(0));
        chk("rd_done_psel", LW'({psel, penable}), LW'(0));
        chk("rd_done_busy", LW'(busy),  LW'(1));
        m0_req = 1'b0;
        @(negedge clk);
        chk("rd_pulse_once", LW'(m0_done), LW'(0));
        chk("rd_idle_busy",  LW'(busy),    LW'(0));

        // Tie from reset, requests held: m0, m1, m0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_lat = 1;
        m0_rw = 1'b0; m0_addr = 12'h200;
        m1_rw = 1'b0; m1_addr = 12'h340;
        m0_req = 1'b1; m1_req = 1'b1;
        wait_done(20, n, d0, d1);
        chk("tie1_who", LW'({d1, d0}), LW'(2'b01));
        chk("tie1_rdata", rdata, line_of(12'h200));
        wait_done(20, n, d0, d1);
        chk("tie2_who", LW'({d1, d0}), LW'(2'b10));
        chk("tie2_rdata", rdata, line_of(12'h340));
        wait_done(20, n, d0, d1);
        chk("tie3_who", LW'({d1, d0}), LW'(2'b01));
        m0_req = 1'b0; m1_req = 1'b0;
        exp_rdata = line_of(12'h200);

        // Write from m1; source data changes after grant to prove latching
        @(negedge clk);
        mem_lat = 5;
        m1_rw = 1'b1; m1_addr = 12'h010; m1_size = 2'b00; m1_wdata = 32'hDEADBEEF; m1_req = 1'b1;
        @(negedge clk);
        chk("wr_setup_rw",    LW'(p_rw),    LW'(1));
        chk("wr_setup_dsize", LW'(p_dsize), LW'(2'b00));
        chk("wr_setup_wdata", LW'(p_wdata), LW'(32'hDEADBEEF));
        chk("wr_setup_addr",  LW'(p_addr),  LW'(12'h010));
        m1_wdata = 32'h0; m1_addr = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_acc_wdata",   LW'(p_wdata), LW'(32'hDEADBEEF));
            chk("wr_acc_penable", LW'(penable), LW'(1));
        end
        wait_done(20, n, d0, d1);
        chk("wr_latency", LW'(n),          LW'(1));
        chk("wr_who",     LW'({d1, d0}),   LW'(2'b10));
        chk("wr_rdata",   rdata,           exp_rdata);
        chk("wr_err",     LW'(err),        LW'(0));
        m1_req = 1'b0; m1_rw = 1'b0;

        // Timeout: p_ready never arrives; request dropped mid-transfer
        @(negedge clk);
        mem_lat = 0;
        m0_rw = 1'b0; m0_addr = 12'h100; m0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m0_req = 1'b0;
        wait_done(100, n, d0, d1);
        chk("tmo_cycles", LW'(n),        LW'(63));
        chk("tmo_who",    LW'({d1, d0}), LW'(2'b01));
        chk("tmo_err",    LW'(err),      LW'(1));
        chk("tmo_rdata",  rdata,         LW'(0));

        // Reset in ACCESS: outputs drop at once, no done afterwards
        @(negedge clk);
        m1_rw = 1'b0; m1_addr = 12'h080; m1_req = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_acc_psel",    LW'(psel),    LW'(0));
        chk("rst_acc_penable", LW'(penable), LW'(0));
        chk("rst_acc_busy",    LW'(busy),    LW'(0));
        m1_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", LW'({m0_done, m1_done, busy}), LW'(0));
        end
        mem_lat = 3;
        m0_rw = 1'b0; m0_addr = 12'h2C8; m0_req = 1'b1;
        @(negedge clk);
        chk("post_rst_grant", LW'({psel, penable}), LW'(2'b10));
        wait_done(20, n, d0, d1);
        chk("post_rst_lat",   LW'(n),        LW'(4));
        chk("post_rst_who",   LW'({d1, d0}), LW'(2'b01));
        chk("post_rst_rdata", rdata,         line_of(12'h2C0));
        m0_req = 1'b0;

        // Late request: m1 raised during m0's transfer waits for IDLE
        @(negedge clk);
        mem_lat = 10;
        m0_addr = 12'h040; m0_req = 1'b1;
        @(negedge clk);
        m1_rw = 1'b0; m1_addr = 12'h3C0; m1_req = 1'b1;
        wait_done(50, n, d0, d1);
        chk("late_m0_who", LW'({d1, d0}), LW'(2'b01));
        chk("late_m0_rdata", rdata, line_of(12'h040));
        m0_req = 1'b0;
        @(negedge clk);
        chk("late_idle_busy", LW'({busy, psel}), LW'(0));
        @(negedge clk);
        chk("late_m1_setup", LW'({psel, penable}), LW'(2'b10));
        chk("late_m1_addr",  LW'(p_addr), LW'(12'h3C0));
        wait_done(50, n, d0, d1);
        chk("late_m1_who",   LW'({d1, d0}), LW'(2'b10));
        chk("late_m1_rdata", rdata, line_of(12'h3C0));
        m1_req = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
